transpose_buffer: RTL
=====================

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 Parameter DATA_W, default 16: signed coefficient width, matching the rotation-stage output width.
REQ-002 Parameter N, default 8: block dimension (N x N); N is a power of two.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  in_row carries a valid row of 1-D row-DCT output.
REQ-006 in_ready  output  1  buffer can accept a row this cycle.
REQ-007 in_row  input  N*DATA_W  row elements; element k occupies bits [k*DATA_W +: DATA_W].
REQ-008 out_valid  output  1  out_col carries a valid column.
REQ-009 out_ready  input  1  downstream (column-pass rotation stage) accepts the column.
REQ-010 out_col  output  N*DATA_W  column elements; element k is row k of the current column, packed as in_row.
REQ-011 out_col_idx  output  log2(N)  index of the column presented on out_col.
REQ-012 out_last  output  1  high when out_col_idx equals N-1 and out_valid is high.

Function
REQ-013 Storage: two N x N banks (ping-pong), each with a full flag; write pointer wr_bank, write row counter wr_row, read pointer rd_bank, read column counter rd_col.
REQ-014 in_ready is high iff the full flag of bank wr_bank is clear and reset is high.
REQ-015 On in_valid && in_ready: in_row is written to bank wr_bank at row wr_row, and wr_row increments.
REQ-016 When the row written has wr_row = N-1: the bank's full flag sets, wr_bank toggles, and wr_row wraps to 0, all at the same edge.
REQ-017 out_valid is high iff the full flag of bank rd_bank is set.
REQ-018 out_col element k equals bank[rd_bank][row k][column rd_col]; out_col_idx equals rd_col; out_col is all-zero when out_valid is low.
REQ-019 On out_valid && out_ready: rd_col increments. At rd_col = N-1: the bank's full flag clears, rd_bank toggles, and rd_col wraps to 0.
REQ-020 Latency: out_valid rises in the cycle after the edge that accepts row N-1 of a block (1 cycle).
REQ-021 Throughput: with out_ready held high and in_valid held high, in_ready never deasserts and one row and one column are transferred every cycle.
REQ-022 While out_valid && !out_ready, out_col, out_col_idx and out_last are held stable.
REQ-023 A write completing bank A and a read completing bank B at the same edge are both honoured; the writer and reader never address the same bank in the same cycle.
REQ-024 With both banks full, in_ready is low and input is ignored until the reader frees a bank; no data is overwritten or dropped.
REQ-025 Data is transferred bit-exact with no arithmetic, sign change or truncation.

Reset
REQ-026 While reset is low at a rising edge: both full flags clear; wr_bank, wr_row, rd_bank and rd_col are set to 0.
REQ-027 After reset: out_valid=0, out_col=0, out_col_idx=0, out_last=0, and in_ready=0 while reset is low and 1 from the first cycle with reset high.
REQ-028 Bank storage is not reset; a partial block or undrained block present at reset is discarded.

Structure
REQ-029 Package fdct_pkg holds DATA_W, N, the signed coefficient typedef, and a row/column array typedef (N coefficients); the rotation and butterfly stages share it.
REQ-030 One sub-module, transpose_bank: one N x N register bank with a row write port and a column read multiplexer, instantiated twice.

Verification
REQ-031 Single block: after reset, drive 8 rows with element(r,c) = r*8+c and out_ready=1 -> out_valid rises 1 cycle after row 7 is accepted; beat c has out_col[k] = k*8+c and out_col_idx=c, with out_last on c=7 only.
REQ-032 Streaming: drive 3 blocks back-to-back with in_valid=1 and out_ready=1 -> in_ready stays 1 for all 24 beats, and 24 output beats follow with no bubble after the initial 8-cycle fill.
REQ-033 Backpressure: hold out_ready=0 and in_valid=1 -> exactly 16 rows are accepted, then in_ready=0 and out_col stays stable; raise out_ready -> columns drain in order and in_ready returns 1 after 8 output beats.
REQ-034 Reset mid-block: accept 5 rows, hold reset low for 1 cycle -> out_valid=0, then in_ready=1; the next 8 rows form the first output block.
REQ-035 Extremes: elements -32768 and 32767 in alternating positions -> output is bit-exact.
REQ-036 Random: randomly toggle in_valid and out_ready over 50 blocks -> all beats match a golden transpose model, with no loss or duplication.

Source files
------------

// File: rtl/fdct_pkg.sv
// Shared types and sizing for the 2-D forward DCT datapath.
// Rotation, butterfly and transpose stages all size themselves from here.
package fdct_pkg;

    localparam int DATA_W = 16;
    localparam int N      = 8;
    localparam int IDX_W  = $clog2(N);

    typedef logic signed [DATA_W-1:0] coef_t;
    typedef coef_t [N-1:0]            vec_t;

endpackage

// File: rtl/transpose_bank.sv
// One N x N coefficient bank: whole-row write port, whole-column read mux.
// Storage is deliberately unreset; the owner tracks validity with a flag.
module transpose_bank #(
    parameter int DATA_W = fdct_pkg::DATA_W,
    parameter int N      = fdct_pkg::N
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [N*DATA_W-1:0]    wr_data,
    input  logic [$clog2(N)-1:0]   rd_col,
    output logic [N*DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem [N][N];

    // Capture a full row, element c lands in column c.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Gather column rd_col, element k taken from row k.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++) begin
            rd_data[k*DATA_W +: DATA_W] = mem[k][rd_col];
        end
    end

endmodule

// File: rtl/transpose_buffer.sv
// Ping-pong row-in / column-out transpose between the two 1-D DCT passes.
// Writer fills one bank while the reader drains the other.
module transpose_buffer #(
    parameter int DATA_W = fdct_pkg::DATA_W,
    parameter int N      = fdct_pkg::N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DATA_W-1:0]    in_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*DATA_W-1:0]    out_col,
    output logic [$clog2(N)-1:0]   out_col_idx,
    output logic                   out_last
);

    localparam int              IW   = $clog2(N);
    localparam logic [IW-1:0]   LAST = IW'(N - 1);

    logic [1:0]          full;
    logic                wr_bank;
    logic                rd_bank;
    logic [IW-1:0]       wr_row;
    logic [IW-1:0]       rd_col;

    logic                wr_fire;
    logic                rd_fire;
    logic                wr_done;
    logic                rd_done;
    logic [1:0]          set_full;
    logic [1:0]          clr_full;
    logic [N*DATA_W-1:0] col_data [2];

    // The writer only ever targets an empty bank and the reader only a
    // full one, so they can never collide on the same bank.
    assign in_ready  = ~full[wr_bank] & reset;
    assign out_valid = full[rd_bank];

    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;
    assign wr_done = wr_fire & (wr_row == LAST);
    assign rd_done = rd_fire & (rd_col == LAST);

    // Per-bank full-flag set/clear strobes from block completion.
    always_comb begin
        set_full          = '0;
        clr_full          = '0;
        set_full[wr_bank] = wr_done;
        clr_full[rd_bank] = rd_done;
    end

    // Pointer and flag state; a write and a read may finish together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_col  <= '0;
        end else begin
            full <= (full & ~clr_full) | set_full;
            if (wr_fire) begin
                wr_row <= wr_row + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_col + 1'b1;
                if (rd_done) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(
            .DATA_W (DATA_W),
            .N      (N)
        ) u_bank (
            .clk     (clk),
            .we      (wr_fire && (wr_bank == 1'(b))),
            .wr_row  (wr_row),
            .wr_data (in_row),
            .rd_col  (rd_col),
            .rd_data (col_data[b])
        );
    end

    assign out_col     = out_valid ? col_data[rd_bank] : '0;
    assign out_col_idx = rd_col;
    assign out_last    = out_valid & (rd_col == LAST);

endmodule
